// File: rtl/mcs6530_bus_master.sv
// MCS6530 RRIOT CPU-side bus initiator: command channel in, 6502-style
// bus cycles out, one response per read beat or per write command.
module mcs6530_bus_master #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4
) (
    input  logic              phi2,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic              cmd_rom,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_last,
    output logic              bus_cs,
    output logic              bus_we_n,
    output logic              bus_rs0,
    output logic [ADDR_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_do,
    input  logic [DATA_W-1:0] bus_di,
    input  logic              bus_oe,
    output logic              busy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    state_t              r_state, w_state;
    logic                r_we, w_we;
    logic                r_rom, w_rom;
    logic                r_err, w_err;
    logic                r_last, w_last;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [DATA_W-1:0]   r_do, w_do;
    logic [DATA_W-1:0]   r_rdata, w_rdata;
    logic [3:0]          r_beats, w_beats;
    logic [WAIT_W-1:0]   r_wait, w_wait;

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_rom   <= 1'b0;
            r_err   <= 1'b0;
            r_last  <= 1'b0;
            r_addr  <= '0;
            r_do    <= '0;
            r_rdata <= '0;
            r_beats <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state;
            r_we    <= w_we;
            r_rom   <= w_rom;
            r_err   <= w_err;
            r_last  <= w_last;
            r_addr  <= w_addr;
            r_do    <= w_do;
            r_rdata <= w_rdata;
            r_beats <= w_beats;
            r_wait  <= w_wait;
        end
    end

    always_comb begin
        w_state = r_state;
        w_we    = r_we;
        w_rom   = r_rom;
        w_err   = r_err;
        w_last  = r_last;
        w_addr  = r_addr;
        w_do    = r_do;
        w_rdata = r_rdata;
        w_beats = r_beats;
        w_wait  = r_wait;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_we    = cmd_we;
                    w_rom   = cmd_rom;
                    w_addr  = cmd_addr;
                    w_beats = cmd_len;
                    w_wait  = '0;
                    if (cmd_we) begin
                        w_do    = cmd_wdata;
                        w_state = S_WRITE;
                    end else begin
                        w_state = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (r_beats != 4'd0) begin
                    w_addr  = r_addr + ADDR_W'(1);
                    w_beats = r_beats - 4'd1;
                end else begin
                    w_rdata = '0;
                    w_err   = 1'b0;
                    w_last  = 1'b1;
                    w_state = S_RESP;
                end
            end
            S_READ: begin
                // First cycle after the address is never sampled: the device
                // registers its read data one cycle late.
                if (r_wait != '0 && bus_oe) begin
                    w_rdata = bus_di;
                    w_err   = 1'b0;
                    w_last  = (r_beats == 4'd0);
                    w_state = S_RESP;
                end else if (r_wait == TMO) begin
                    w_rdata = '0;
                    w_err   = 1'b1;
                    w_last  = 1'b1;
                    w_state = S_RESP;
                end else begin
                    w_wait = r_wait + WAIT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (!r_we && !r_err && r_beats != 4'd0) begin
                        w_addr  = r_addr + ADDR_W'(1);
                        w_beats = r_beats - 4'd1;
                        w_wait  = '0;
                        w_state = S_READ;
                    end else begin
                        w_state = S_IDLE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign rsp_last  = r_last;
    assign bus_cs    = (r_state == S_WRITE) || (r_state == S_READ);
    assign bus_we_n  = (r_state != S_WRITE);
    assign bus_rs0   = r_rom;
    assign bus_a     = r_addr;
    assign bus_do    = r_do;

endmodule
